// File: rtl/circular_dma_reader_pkg.sv
// circular_dma_reader_pkg: FSM states, AXI response code, 4 KB boundary and irq bit indices
package circular_dma_reader_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_UPDATE, ST_ERROR} state_t;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [31:0] BOUNDARY_4K = 32'd4096;
  localparam int IRQ_DRAINED = 0;
  localparam int IRQ_RD_ERR = 1;
endpackage

// File: rtl/circular_dma_reader_len.sv
// circular_dma_reader_len: combinational burst sizing for the next read burst
//   in:  mem_base, mem_size, write_ptr, read_ptr
//   out: addr (mem_base + read_ptr), avail_nz (data pending), arlen (beats - 1)
//   beats = min(C_MAX_BURST, avail, bytes to buffer end, bytes to 4 KB boundary) / B
module circular_dma_reader_len
  import circular_dma_reader_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_AXIS_WIDTH = 64,
  parameter int C_MAX_BURST = 16
) (
  input  logic [C_ADDR_WIDTH-1:0] mem_base,
  input  logic [31:0]             mem_size,
  input  logic [31:0]             write_ptr,
  input  logic [31:0]             read_ptr,
  output logic [C_ADDR_WIDTH-1:0] addr,
  output logic                    avail_nz,
  output logic [7:0]              arlen
);
  localparam int SH = $clog2(C_AXIS_WIDTH / 8);
  logic [31:0] avail, n_avail, n_wrap, n_4k, m0, m1, m2;
  always_comb begin
    addr = mem_base + C_ADDR_WIDTH'(read_ptr);
    // modulo-mem_size distance; 32-bit wraparound of the sum is harmless since the result < mem_size
    avail = write_ptr >= read_ptr ? write_ptr - read_ptr : write_ptr + mem_size - read_ptr;
    n_avail = avail >> SH;
    n_wrap = (mem_size - read_ptr) >> SH;
    n_4k = (BOUNDARY_4K - 32'(addr[11:0])) >> SH;
    m0 = n_avail < 32'(C_MAX_BURST) ? n_avail : 32'(C_MAX_BURST);
    m1 = n_wrap < m0 ? n_wrap : m0;
    m2 = n_4k < m1 ? n_4k : m1;
    avail_nz = avail != 32'd0;
    arlen = 8'(m2 - 32'd1);
  end
endmodule

// File: rtl/circular_dma_reader.sv
// circular_dma_reader: drains a circular memory buffer via AXI4 read bursts onto AXI4-Stream
//   control: enable, mem_base, mem_size, write_ptr -> read_ptr, irq[1:0] (w1c via clear_irq), busy
//   M_AXI:   AR (araddr/arlen/arvalid/arready), R (rdata/rresp/rlast/rvalid/rready)
//   M_AXIS:  tdata/tlast/tvalid/tready, combinationally forwarded from R during ST_DATA
//   Option:  define CIRCULAR_DMA_READER_ERR_CHECK_EN to trap non-OKAY rresp into ST_ERROR
module circular_dma_reader
  import circular_dma_reader_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_AXIS_WIDTH = 64,
  parameter int C_MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [C_ADDR_WIDTH-1:0] mem_base,
  input  logic [31:0]             mem_size,
  input  logic [31:0]             write_ptr,
  output logic [31:0]             read_ptr,
  input  logic [1:0]              clear_irq,
  output logic [1:0]              irq,
  output logic                    busy,
  output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [C_AXIS_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [C_AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);
  localparam int SH = $clog2(C_AXIS_WIDTH / 8);
  state_t state, state_nx;
  logic [C_ADDR_WIDTH-1:0] len_addr;
  logic [7:0] len_arlen;
  logic [31:0] wp_q, ptr_sum, ptr_nx;
  logic [1:0] irq_set;
  logic avail_nz, start, beat, err_nx;
  circular_dma_reader_len #(
    .C_ADDR_WIDTH(C_ADDR_WIDTH),
    .C_AXIS_WIDTH(C_AXIS_WIDTH),
    .C_MAX_BURST(C_MAX_BURST)
  ) u_len (
    .mem_base(mem_base),
    .mem_size(mem_size),
    .write_ptr(write_ptr),
    .read_ptr(read_ptr),
    .addr(len_addr),
    .avail_nz(avail_nz),
    .arlen(len_arlen)
  );
`ifdef CIRCULAR_DMA_READER_ERR_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= state == ST_DATA ? err_nx : 1'b0;
  assign err_nx = err_q || (beat && m_axi_rresp != AXI_RESP_OKAY);
  assign irq_set[IRQ_RD_ERR] = beat && m_axi_rlast && err_nx;
`else
  logic unused_rresp;
  assign unused_rresp = ^m_axi_rresp;
  assign err_nx = 1'b0;
  assign irq_set[IRQ_RD_ERR] = 1'b0;
`endif
  always_comb begin
    start = enable && avail_nz;
    beat = state == ST_DATA && m_axi_rvalid && m_axis_tready;
    ptr_sum = read_ptr + ((32'(m_axi_arlen) + 32'd1) << SH);
    ptr_nx = ptr_sum == mem_size ? 32'd0 : ptr_sum;
    // compare against the write_ptr captured at burst start, not the live input
    irq_set[IRQ_DRAINED] = state == ST_UPDATE && ptr_nx == wp_q;
    state_nx = state == ST_IDLE  ? (start ? ST_ADDR : ST_IDLE)
             : state == ST_ADDR  ? (m_axi_arready ? ST_DATA : ST_ADDR)
             : state == ST_DATA  ? (beat && m_axi_rlast ? (err_nx ? ST_ERROR : ST_UPDATE) : ST_DATA)
             : state == ST_ERROR ? (enable ? ST_ERROR : ST_IDLE)
             : ST_IDLE;
    m_axi_arvalid = state == ST_ADDR;
    m_axi_rready = state == ST_DATA && m_axis_tready;
    m_axis_tvalid = state == ST_DATA && m_axi_rvalid;
    m_axis_tdata = state == ST_DATA ? m_axi_rdata : '0;
    m_axis_tlast = state == ST_DATA && m_axi_rlast;
    busy = state != ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      read_ptr <= '0;
      irq <= '0;
      m_axi_araddr <= '0;
      m_axi_arlen <= '0;
      wp_q <= '0;
    end else begin
      state <= state_nx;
      irq <= (irq & ~clear_irq) | irq_set;
      if (state == ST_IDLE && !enable) read_ptr <= '0;
      if (state == ST_IDLE && start) begin
        m_axi_araddr <= len_addr;
        m_axi_arlen <= len_arlen;
        wp_q <= write_ptr;
      end
      if (state == ST_UPDATE) read_ptr <= ptr_nx;
    end
endmodule
